pio_mem_bridge: RTL and testbench

- Sits directly downstream of the HPS address PIO.
- Consumes the 16-bit address word, a 32-bit write-data PIO word and a 2-bit command PIO word, all driven by HPS software.
- Turns a software command into a single arbitrated read or write on the neural-network weight/activation RAM port.
- Returns read data and a status word, both for input PIOs read back by the HPS.

---
 rtl/pio_mem_bridge.sv | 112 +++++++++++
 tb/tb_pio_mem_bridge.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pio_mem_bridge.sv
// Bridges HPS PIO words (address, write data, go/rw control) to one arbitrated RAM access per command.
// Optional: define PIO_MEM_BRIDGE_RANGE_CHECK_EN to reject addresses >= MEM_DEPTH with the err flag.
module pio_mem_bridge #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2,
  parameter int MEM_DEPTH  = 65536
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] hps_addr,
  input  logic [DATA_W-1:0] hps_wdata,
  input  logic [1:0]        hps_ctrl,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata_out,
  output logic [3:0]        status
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(RD_LATENCY - 1);

  state_t     state;
  logic       go_q;
  logic [2:0] cnt;
  logic       err, overrun, done, busy;
  logic       start;
  logic       addr_oob;

  assign start  = hps_ctrl[0] & ~go_q;
  assign status = {err, overrun, done, busy};

`ifdef PIO_MEM_BRIDGE_RANGE_CHECK_EN
  assign addr_oob = (32'(hps_addr) >= 32'(MEM_DEPTH));
`else
  // Depth only matters when the range check is built in.
  logic unused_depth;
  assign unused_depth = (MEM_DEPTH > 0);
  assign addr_oob     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      go_q      <= 1'b0;
      cnt       <= 3'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_out <= '0;
      err       <= 1'b0;
      overrun   <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      go_q <= hps_ctrl[0];
      case (state)
        IDLE: begin
          if (start) begin
            if (addr_oob) begin
              // Rejected command completes immediately without touching the RAM.
              err  <= 1'b1;
              done <= 1'b1;
            end else begin
              err       <= 1'b0;
              done      <= 1'b0;
              busy      <= 1'b1;
              mem_addr  <= hps_addr;
              mem_wdata <= hps_wdata;
              mem_we    <= hps_ctrl[1];
              mem_req   <= 1'b1;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (start) overrun <= 1'b1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              cnt   <= CNT_LOAD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (start) overrun <= 1'b1;
          if (cnt == 3'd0) begin
            rdata_out <= mem_rdata;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_mem_bridge.sv
// Scoreboard bench for pio_mem_bridge: a driver queues expected RAM accesses and completions,
// monitors pop and compare them as the DUT presents accesses and done/err edges.
module tb_pio_mem_bridge;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1024;
`ifdef PIO_MEM_BRIDGE_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic              clk;
  logic              reset_n;
  logic [ADDR_W-1:0] hps_addr;
  logic [DATA_W-1:0] hps_wdata;
  logic [1:0]        hps_ctrl;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rdata_out;
  logic [3:0]        status;

  pio_mem_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LAT), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hps_addr(hps_addr), .hps_wdata(hps_wdata),
    .hps_ctrl(hps_ctrl), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rdata_out(rdata_out), .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic we; logic [15:0] addr; logic [31:0] wdata;} acc_t;
  typedef struct {logic [31:0] rdata; logic [3:0] st;} cmp_t;

  acc_t exp_acc[$];
  cmp_t exp_cmp[$];

  logic [31:0] ref_mem [0:DEPTH-1];  // reference model contents, updated by the driver
  logic [31:0] ram     [0:DEPTH-1];  // environment RAM, updated by observed accesses
  logic [31:0] last_rd;
  logic        exp_ovr;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          gnt_mode = 0;          // 0 random, 1 always grant, 2 never grant

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    mem_gnt = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (gnt_mode)
        0:       mem_gnt = ($urandom_range(0, 3) != 0);
        1:       mem_gnt = 1'b1;
        default: mem_gnt = 1'b0;
      endcase
    end
  end

  // Monitor: RAM accesses, request hold stability, read-data return and completions.
  initial begin
    logic        prev_req, prev_we, prev_done, prev_err, rd_valid;
    logic [15:0] prev_addr;
    logic [31:0] prev_wdata;
    int          rd_due;
    logic [9:0]  rd_addr;
    acc_t        e;
    cmp_t        c;
    prev_req = 0; prev_we = 0; prev_done = 0; prev_err = 0; rd_valid = 0;
    prev_addr = '0; prev_wdata = '0; rd_due = 0; rd_addr = '0;
    mem_rdata = $urandom;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (mem_req && prev_req) begin
          chk("hold_addr", 32'(mem_addr), 32'(prev_addr));
          chk("hold_we", 32'(mem_we), 32'(prev_we));
          chk("hold_wdata", mem_wdata, prev_wdata);
          chk("busy_while_req", 32'(status[0]), 32'd1);
        end
        if (mem_req && mem_gnt) begin
          $display("access we=%0d addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);
          if (exp_acc.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL extra_access: got access at %h, required none", mem_addr);
          end else begin
            e = exp_acc.pop_front();
            chk("acc_we", 32'(mem_we), 32'(e.we));
            chk("acc_addr", 32'(mem_addr), 32'(e.addr));
            chk("acc_wdata", mem_wdata, e.wdata);
            if (mem_we) ram[mem_addr[9:0]] = mem_wdata;
            else begin
              rd_valid = 1'b1;
              rd_due   = cyc + 1 + RD_LAT;
              rd_addr  = mem_addr[9:0];
            end
          end
        end
        if ((status[1] && !prev_done) || (status[3] && !prev_err)) begin
          if (exp_cmp.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL extra_done: got status %b, required no completion", status);
          end else begin
            c = exp_cmp.pop_front();
            $display("complete rdata_out=%h status=%b", rdata_out, status);
            chk("rdata_out", rdata_out, c.rdata);
            chk("status", 32'(status), 32'(c.st));
          end
        end
      end
      // Read data is valid only on the edge exactly RD_LAT cycles after the grant edge.
      mem_rdata = (rd_valid && (cyc + 1 == rd_due)) ? ram[rd_addr] : $urandom;
      if (rd_valid && (cyc + 1 >= rd_due)) rd_valid = 1'b0;
      prev_req = mem_req; prev_we = mem_we; prev_addr = mem_addr; prev_wdata = mem_wdata;
      prev_done = status[1]; prev_err = status[3];
    end
  end

  // Queue expectations for one command from the model's view of memory and flags.
  task automatic expect_cmd(input bit we, input logic [15:0] a, input logic [31:0] d,
                            input bit ovr, output bit oob);
    oob = RANGE_EN && (int'(a) >= DEPTH);
    if (ovr) exp_ovr = 1'b1;
    if (!oob) begin
      exp_acc.push_back('{we, a, d});
      if (we) ref_mem[a[9:0]] = d;
      else    last_rd = ref_mem[a[9:0]];
    end
    exp_cmp.push_back('{last_rd, {oob, exp_ovr, 1'b1, 1'b0}});
  endtask

  task automatic wait_done(input int k0, input bit timed, input int exp_k);
    int k;
    bit fin;
    k = k0; fin = 0;
    while (!fin && k < 400) begin
      @(negedge clk); k++;
      if (k >= 2 && !status[0] && status[1]) fin = 1;
    end
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: got no completion after %0d cycles, required done", k);
    end else if (timed) chk("latency", 32'(k), 32'(exp_k));
    @(posedge clk); #1;
    hps_ctrl[0] = 1'b0;
    gnt_mode = 0;
  endtask

  task automatic run_cmd(input bit we, input logic [15:0] a, input logic [31:0] d,
                         input bit ovr, input int stall, input bit timed);
    bit oob;
    int k;
    expect_cmd(we, a, d, ovr, oob);
    gnt_mode = (stall > 0) ? 2 : (timed ? 1 : 0);
    @(posedge clk); #1;
    hps_addr = a; hps_wdata = d; hps_ctrl = {we, 1'b1};
    k = 0;
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1; k++;
        if (ovr && i == 1) hps_ctrl[0] = 1'b0;
        if (ovr && i == 2) hps_ctrl[0] = 1'b1;
      end
      gnt_mode = 1;
    end
    wait_done(k, timed && stall == 0, oob ? 2 : (we ? 3 : 3 + RD_LAT));
  endtask

  initial begin
    bit oob;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = $urandom;
      ram[i]     = ref_mem[i];
    end
    last_rd = '0; exp_ovr = 1'b0;
    reset_n = 1'b0; hps_ctrl = 2'b01; hps_addr = 16'h0010; hps_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_status", 32'(status), 32'd0);
    chk("reset_req", 32'(mem_req), 32'd0);
    chk("reset_rdata", rdata_out, 32'd0);

    // go still high at release starts a read on the first cycle.
    expect_cmd(1'b0, 16'h0010, '0, 1'b0, oob);
    gnt_mode = 1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_done(0, 1'b1, 3 + RD_LAT);

    run_cmd(1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 0, 1'b1);
    run_cmd(1'b0, 16'h0010, '0, 1'b0, 0, 1'b1);
    run_cmd(1'b0, 16'h0123, $urandom, 1'b0, 10, 1'b0);
    run_cmd(1'b1, 16'h0123, $urandom, 1'b0, 10, 1'b0);

    for (int n = 0; n < 30; n++)
      run_cmd(1'($urandom_range(0, 1)), 16'($urandom_range(0, DEPTH - 1)), $urandom,
              1'b0, 0, 1'($urandom_range(0, 1)));

    run_cmd(1'b0, 16'h0200, '0, 1'b1, 10, 1'b0);
    for (int n = 0; n < 10; n++)
      run_cmd(1'($urandom_range(0, 1)), 16'($urandom_range(0, DEPTH - 1)), $urandom,
              1'b0, 0, 1'($urandom_range(0, 1)));

    if (RANGE_EN) begin
      run_cmd(1'b0, 16'h0400, '0, 1'b0, 0, 1'b1);
      run_cmd(1'b0, 16'h03FF, '0, 1'b0, 0, 1'b1);
    end

    repeat (5) @(negedge clk);
    chk("acc_pending", 32'(exp_acc.size()), 32'd0);
    chk("cmp_pending", 32'(exp_cmp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
